// File: rtl/vga_frame_monitor.sv
// rtl/vga_frame_monitor.sv - VGA sink checker: rebuilds sync timing, declares lock, tracks a target colour box per frame
module vga_frame_monitor #(
    parameter int H_ACT_BEGIN = 143,
    parameter int H_ACT_END   = 783,
    parameter int V_ACT_BEGIN = 34,
    parameter int V_ACT_END   = 514,
    parameter int LOCK_FRAMES = 2,
    parameter int H_TIMEOUT   = 1023
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        pix_en,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [11:0] rgb,
    input  logic [11:0] target_rgb,
    output logic        locked,
    output logic [9:0]  h_total,
    output logic [9:0]  v_total,
    output logic        frame_done,
    output logic        tgt_valid,
    output logic [9:0]  tgt_left,
    output logic [9:0]  tgt_right,
    output logic [9:0]  tgt_top,
    output logic [9:0]  tgt_bottom,
    output logic [18:0] tgt_pixels
);

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

    localparam int          MW  = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
    localparam logic [9:0]  HB  = 10'(H_ACT_BEGIN);
    localparam logic [9:0]  HE  = 10'(H_ACT_END);
    localparam logic [9:0]  VB  = 10'(V_ACT_BEGIN);
    localparam logic [9:0]  VE  = 10'(V_ACT_END);
    localparam logic [10:0] TMO = 11'(H_TIMEOUT);
    localparam logic [MW-1:0] LOCK_N = MW'(LOCK_FRAMES);

    state_t        state, state_next;
    logic [MW-1:0] mcnt, mcnt_next;
    logic          publish;

    logic          hs_prev, vs_line;
    logic [9:0]    hcnt, vcnt, h_meas, v_meas, h_frame;
    logic [10:0]   wd;
    logic          first_valid, line_bad;
    logic [11:0]   tgt_lat;
    logic [9:0]    w_left, w_right, w_top, w_bottom;
    logic [18:0]   w_count;

    logic          hs_fall, frame_start, timeout, frame_ok, frame_match, hit, w_any;
    logic [9:0]    line_len, frame_lines, hx, vy, x, y;
    logic [11:0]   tgt_cur;

    assign hs_fall     = hs_prev & ~hsync;
    assign frame_start = hs_fall & ~vsync & vs_line;
    assign timeout     = (wd >= TMO);
    assign line_len    = hcnt + 10'd1;
    assign frame_lines = vcnt + 10'd1;

    // hx/vy are the coordinates of the pixel on this strobe, so the
    // frame-start pixel already lands at (0,0) of the new frame.
    assign hx = hs_fall ? 10'd0 : ((hcnt == 10'h3ff) ? hcnt : hcnt + 10'd1);
    assign vy = frame_start ? 10'd0 : (hs_fall ? vcnt + 10'd1 : vcnt);
    assign x  = hx - HB;
    assign y  = vy - VB;

    assign tgt_cur = frame_start ? target_rgb : tgt_lat;
    assign hit     = (hx >= HB) && (hx < HE) && (vy >= VB) && (vy < VE) && (rgb == tgt_cur);

    // Adjacent-line comparison catches any line differing from the first one.
    assign frame_ok    = ~line_bad & ~(first_valid & (line_len != h_meas));
    assign frame_match = frame_ok & (line_len == h_frame) & (frame_lines == v_meas);
    assign w_any       = (w_count != 19'd0);
    assign locked      = (state == LOCKED);

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state <= SEARCH;
            mcnt  <= '0;
        end else begin
            state <= state_next;
            mcnt  <= mcnt_next;
        end
    end

    always_comb begin
        state_next = state;
        mcnt_next  = mcnt;
        publish    = 1'b0;
        if (pix_en) begin
            if (timeout) begin
                state_next = SEARCH;
                mcnt_next  = '0;
            end else if (frame_start) begin
                case (state)
                    SEARCH: begin
                        state_next = ACQUIRE;
                        mcnt_next  = '0;
                    end
                    ACQUIRE: begin
                        publish = 1'b1;
                        if (frame_match && mcnt != '0) begin
                            mcnt_next = mcnt + MW'(1);
                            if (mcnt + MW'(1) >= LOCK_N)
                                state_next = LOCKED;
                        end else begin
                            mcnt_next = MW'(1);
                        end
                    end
                    LOCKED: begin
                        publish = 1'b1;
                        if (!frame_match) begin
                            state_next = ACQUIRE;
                            mcnt_next  = MW'(1);
                        end
                    end
                    default: state_next = SEARCH;
                endcase
            end
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            hs_prev     <= 1'b1;
            vs_line     <= 1'b1;
            hcnt        <= '0;
            vcnt        <= '0;
            h_meas      <= '0;
            v_meas      <= '0;
            h_frame     <= '0;
            wd          <= '0;
            first_valid <= 1'b0;
            line_bad    <= 1'b0;
            tgt_lat     <= '0;
            w_left      <= '0;
            w_right     <= '0;
            w_top       <= '0;
            w_bottom    <= '0;
            w_count     <= '0;
        end else if (pix_en) begin
            hs_prev <= hsync;
            hcnt    <= hx;
            vcnt    <= vy;
            if (hs_fall) begin
                wd      <= '0;
                vs_line <= vsync;
                h_meas  <= line_len;
            end else if (wd != 11'h7ff) begin
                wd <= wd + 11'd1;
            end
            if (frame_start) begin
                v_meas      <= frame_lines;
                h_frame     <= line_len;
                first_valid <= 1'b0;
                line_bad    <= 1'b0;
                tgt_lat     <= target_rgb;
                w_left      <= hit ? x : 10'h3ff;
                w_right     <= hit ? x : 10'd0;
                w_top       <= hit ? y : 10'h3ff;
                w_bottom    <= hit ? y : 10'd0;
                w_count     <= hit ? 19'd1 : 19'd0;
            end else begin
                if (hs_fall) begin
                    first_valid <= 1'b1;
                    if (first_valid && line_len != h_meas)
                        line_bad <= 1'b1;
                end
                if (hit) begin
                    if (x < w_left)   w_left   <= x;
                    if (x > w_right)  w_right  <= x;
                    if (y < w_top)    w_top    <= y;
                    if (y > w_bottom) w_bottom <= y;
                    if (w_count != 19'h7ffff)
                        w_count <= w_count + 19'd1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            frame_done <= 1'b0;
            h_total    <= '0;
            v_total    <= '0;
            tgt_valid  <= 1'b0;
            tgt_left   <= '0;
            tgt_right  <= '0;
            tgt_top    <= '0;
            tgt_bottom <= '0;
            tgt_pixels <= '0;
        end else begin
            frame_done <= publish;
            if (publish) begin
                h_total    <= line_len;
                v_total    <= frame_lines;
                tgt_valid  <= w_any;
                tgt_left   <= w_any ? w_left   : 10'd0;
                tgt_right  <= w_any ? w_right  : 10'd0;
                tgt_top    <= w_any ? w_top    : 10'd0;
                tgt_bottom <= w_any ? w_bottom : 10'd0;
                tgt_pixels <= w_count;
            end
        end
    end

endmodule

// File: tb/tb_vga_frame_monitor.sv
// tb/tb_vga_frame_monitor.sv - self-checking bench for vga_frame_monitor on a scaled-down raster
module tb_vga_frame_monitor;

    localparam int H_TOT = 32;
    localparam int HB = 8, HE = 28, VB = 3, VE = 14;
    localparam logic [11:0] TGT = 12'h0f0;
    localparam logic [11:0] BG  = 12'hfff;

    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic        pix_en = 1'b0;
    logic        hsync = 1'b1;
    logic        vsync = 1'b1;
    logic [11:0] rgb = 12'h000;
    logic [11:0] target_rgb = TGT;
    logic        locked, frame_done, tgt_valid;
    logic [9:0]  h_total, v_total, tgt_left, tgt_right, tgt_top, tgt_bottom;
    logic [18:0] tgt_pixels;

    always #5 clock = ~clock;

    vga_frame_monitor #(
        .H_ACT_BEGIN(HB), .H_ACT_END(HE), .V_ACT_BEGIN(VB), .V_ACT_END(VE),
        .LOCK_FRAMES(2), .H_TIMEOUT(1023)
    ) dut (
        .clock(clock), .rst(rst), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
        .rgb(rgb), .target_rgb(target_rgb), .locked(locked), .h_total(h_total),
        .v_total(v_total), .frame_done(frame_done), .tgt_valid(tgt_valid),
        .tgt_left(tgt_left), .tgt_right(tgt_right), .tgt_top(tgt_top),
        .tgt_bottom(tgt_bottom), .tgt_pixels(tgt_pixels)
    );

    int checks = 0, errors = 0;
    bit done = 0;
    int cyc = 0, fd_count = 0, fd_last = 0, fd_gap = 0;

    int exp_locked = 0, exp_h = 0, exp_v = 0, exp_fd = 0, exp_tv = 0;
    int exp_l = 0, exp_r = 0, exp_t = 0, exp_b = 0, exp_n = 0;

    bit rect_en = 0, px_en = 0;
    int rx0 = 0, rx1 = 0, ry0 = 0, ry1 = 0, px = 0, py = 0;

    int pend_h = 0, pend_v = 0, pend_n = 0, pend_l = 0, pend_r = 0, pend_t = 0, pend_b = 0;
    int m_st = 0, m_mcnt = 0, m_ph = 0, m_pv = 0, m_since = 0;

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        forever begin
            @(negedge clock);
            if (!done) begin
                checks++;
                if (int'(locked) != exp_locked || int'(h_total) != exp_h || int'(v_total) != exp_v ||
                    int'(frame_done) != exp_fd || int'(tgt_valid) != exp_tv || int'(tgt_left) != exp_l ||
                    int'(tgt_right) != exp_r || int'(tgt_top) != exp_t || int'(tgt_bottom) != exp_b ||
                    int'(tgt_pixels) != exp_n) begin
                    errors++;
                    $display("FAIL outputs t=%0t got lk=%0d h=%0d v=%0d fd=%0d tv=%0d box=%0d/%0d/%0d/%0d n=%0d want lk=%0d h=%0d v=%0d fd=%0d tv=%0d box=%0d/%0d/%0d/%0d n=%0d",
                             $time, locked, h_total, v_total, frame_done, tgt_valid, tgt_left, tgt_right,
                             tgt_top, tgt_bottom, tgt_pixels, exp_locked, exp_h, exp_v, exp_fd, exp_tv,
                             exp_l, exp_r, exp_t, exp_b, exp_n);
                end
                if (frame_done === 1'b1) begin
                    fd_count++;
                    fd_gap  = cyc - fd_last;
                    fd_last = cyc;
                end
            end
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    function automatic logic [11:0] pix_color(input int hc, input int vc);
        if (rect_en && hc >= rx0 && hc <= rx1 && vc >= ry0 && vc <= ry1) return TGT;
        if (px_en && hc == px && vc == py) return TGT;
        return BG;
    endfunction

    task automatic compute_pend(input int nlines);
        pend_h = H_TOT; pend_v = nlines; pend_n = 0;
        pend_l = 1023; pend_r = 0; pend_t = 1023; pend_b = 0;
        for (int vc = 0; vc < nlines; vc++)
            for (int hc = 0; hc < H_TOT; hc++)
                if (hc >= HB && hc < HE && vc >= VB && vc < VE && pix_color(hc, vc) == TGT) begin
                    pend_n++;
                    if (hc - HB < pend_l) pend_l = hc - HB;
                    if (hc - HB > pend_r) pend_r = hc - HB;
                    if (vc - VB < pend_t) pend_t = vc - VB;
                    if (vc - VB > pend_b) pend_b = vc - VB;
                end
    endtask

    task automatic model_fs();
        bit same;
        if (m_st == 0) begin
            m_st = 1; m_mcnt = 0;
        end else begin
            same   = (pend_h == m_ph) && (pend_v == m_pv);
            exp_h  = pend_h; exp_v = pend_v; exp_n = pend_n; exp_fd = 1;
            exp_tv = (pend_n != 0) ? 1 : 0;
            exp_l  = exp_tv ? pend_l : 0; exp_r = exp_tv ? pend_r : 0;
            exp_t  = exp_tv ? pend_t : 0; exp_b = exp_tv ? pend_b : 0;
            if (m_st == 1) begin
                if (same && m_mcnt > 0) m_mcnt++;
                else m_mcnt = 1;
                if (m_mcnt >= 2) begin m_st = 2; exp_locked = 1; end
            end else if (!same) begin
                m_st = 1; m_mcnt = 1; exp_locked = 0;
            end
        end
        m_ph = pend_h; m_pv = pend_v;
    endtask

    task automatic model_step(input bit ls, input bit fs);
        int now;
        now = m_since + 1;
        if (now >= 1024) begin
            m_st = 0; exp_locked = 0;
        end else if (fs) begin
            model_fs();
        end
        m_since = ls ? 0 : ((now > 4000) ? 4000 : now);
    endtask

    task automatic model_reset();
        exp_locked = 0; exp_h = 0; exp_v = 0; exp_fd = 0; exp_tv = 0;
        exp_l = 0; exp_r = 0; exp_t = 0; exp_b = 0; exp_n = 0;
        m_st = 0; m_mcnt = 0; m_ph = 0; m_pv = 0; m_since = 0;
    endtask

    task automatic strobe(input logic hs, input logic vs, input logic [11:0] c, input bit ls, input bit fs);
        hsync = hs; vsync = vs; rgb = c; pix_en = 1'b1;
        @(posedge clock); #1;
        pix_en = 1'b0;
        model_step(ls, fs);
        @(posedge clock); #1;
        exp_fd = 0;
        @(posedge clock);
        @(posedge clock); #1;
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_locked", int'(locked), 0);
        check("rst_h_total", int'(h_total), 0);
        check("rst_tgt_pixels", int'(tgt_pixels), 0);
        @(posedge clock); #1;
        rst = 1'b0;
    endtask

    task automatic send_frame(input int nlines, input int stop_line, input int hold_n, input int rst_line);
        for (int l = 0; l < nlines; l++) begin
            if (l == stop_line) begin
                for (int i = 1; i <= hold_n; i++) begin
                    strobe(1'b1, 1'b1, 12'h000, 1'b0, 1'b0);
                    if (i == 992) check("pre_timeout_locked", int'(locked), 1);
                    if (i == 993) check("timeout_locked", int'(locked), 0);
                end
            end
            for (int p = 0; p < H_TOT; p++) begin
                strobe((p < 4) ? 1'b0 : 1'b1, (l < 2) ? 1'b0 : 1'b1, pix_color(p, l), p == 0, (p == 0) && (l == 0));
                if (l == rst_line && p == 16) do_reset();
            end
        end
        compute_pend(nlines);
    endtask

    int fd_before;

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check("reset_locked", int'(locked), 0);
        check("reset_v_total", int'(v_total), 0);
        check("reset_frame_done", int'(frame_done), 0);
        check("reset_tgt_valid", int'(tgt_valid), 0);
        rst = 1'b0;

        // standard stream, nothing of the target colour
        repeat (4) send_frame(16, -1, 0, -1);
        check("std_locked", int'(locked), 1);
        check("std_h_total", int'(h_total), 32);
        check("std_v_total", int'(v_total), 16);
        check("std_tgt_valid", int'(tgt_valid), 0);
        check("std_fd_count", fd_count, 3);
        check("std_fd_gap", fd_gap, 2048);

        // target square inside the active area
        rect_en = 1; rx0 = 12; rx1 = 17; ry0 = 5; ry1 = 8;
        repeat (2) send_frame(16, -1, 0, -1);
        check("sq_left", int'(tgt_left), 4);
        check("sq_right", int'(tgt_right), 9);
        check("sq_top", int'(tgt_top), 2);
        check("sq_bottom", int'(tgt_bottom), 5);
        check("sq_pixels", int'(tgt_pixels), 24);
        check("sq_valid", int'(tgt_valid), 1);

        // square covering the active corners, plus one pixel just before the active start
        rx0 = 8; rx1 = 29; ry0 = 0; ry1 = 13; px_en = 1; px = 7; py = 9;
        repeat (2) send_frame(16, -1, 0, -1);
        check("corner_left", int'(tgt_left), 0);
        check("corner_right", int'(tgt_right), 19);
        check("corner_top", int'(tgt_top), 0);
        check("corner_bottom", int'(tgt_bottom), 10);
        check("corner_pixels", int'(tgt_pixels), 220);
        rect_en = 0; px_en = 0;

        // one long frame breaks lock, two good frames restore it
        send_frame(17, -1, 0, -1);
        send_frame(16, -1, 0, -1);
        check("long_unlocked", int'(locked), 0);
        check("long_v_total", int'(v_total), 17);
        send_frame(16, -1, 0, -1);
        check("relock_pending", int'(locked), 0);
        send_frame(16, -1, 0, -1);
        check("relocked", int'(locked), 1);

        // hsync stuck high mid-frame
        send_frame(16, 6, 1100, -1);
        fd_before = fd_count;
        send_frame(16, -1, 0, -1);
        check("tmo_no_fd", fd_count, fd_before);
        send_frame(16, -1, 0, -1);
        check("tmo_fd_resumed", fd_count, fd_before + 1);
        send_frame(16, -1, 0, -1);
        check("tmo_relocked", int'(locked), 1);

        // reset pulsed mid-frame while locked
        send_frame(16, -1, 0, 8);
        fd_before = fd_count;
        send_frame(16, -1, 0, -1);
        check("rst_no_fd", fd_count, fd_before);
        send_frame(16, -1, 0, -1);
        check("rst_unlocked", int'(locked), 0);
        send_frame(16, -1, 0, -1);
        check("rst_relocked", int'(locked), 1);

        done = 1;
        @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
